// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives the s/r pins of an SR latch from a valid/ready
// command port. Each command produces one clean pulse of PULSE_CYC cycles,
// a dead time of GAP_CYC cycles, then waits up to TIMEOUT_CYC cycles for the
// synchronized q/qb feedback to show the commanded state.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a command, s=r=0
// PULSE  | s (set) or r (reset) held high, counter counts down
// GAP    | dead time, s=r=0, counter counts down
// CHECK  | s=r=0, compare synced feedback against dir, counter counts up
module sr_latch_driver #(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cmd_valid,
  input  logic i_cmd_set,
  output logic o_cmd_ready,
  input  logic i_q_fb,
  input  logic i_qb_fb,
  output logic o_s,
  output logic o_r,
  output logic o_done,
  output logic o_fail,
  output logic o_err,
  input  logic i_err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Counter reload values; a zero-length gap is skipped entirely.
  localparam bit              HAS_GAP    = (GAP_CYC > 0);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_s;
  logic             r_r;
  logic             r_done;
  logic             r_fail;
  logic             r_err;
  logic             r_q_meta;
  logic             r_q_sync;
  logic             r_qb_meta;
  logic             r_qb_sync;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_s_nxt;
  logic             w_r_nxt;
  logic             w_done_nxt;
  logic             w_fail_nxt;
  logic             w_match;

  // Latch reached the commanded state; q==qb (invalid latch state) never matches.
  assign w_match = (r_q_sync == r_dir) && (r_qb_sync == ~r_dir);

  // Two-flop synchronizers for the asynchronous latch feedback.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_meta  <= 1'b0;
      r_q_sync  <= 1'b0;
      r_qb_meta <= 1'b0;
      r_qb_sync <= 1'b0;
    end else begin
      r_q_meta  <= i_q_fb;
      r_q_sync  <= r_q_meta;
      r_qb_meta <= i_qb_fb;
      r_qb_sync <= r_qb_meta;
    end
  end

  // Next-state, counter and drive decode; s and r are never both requested.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_done_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_dir_nxt   = i_cmd_set;
          w_s_nxt     = i_cmd_set;
          w_r_nxt     = ~i_cmd_set;
          w_cnt_nxt   = PULSE_LOAD;
          w_state_nxt = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          if (HAS_GAP) begin
            w_cnt_nxt   = GAP_LOAD;
            w_state_nxt = ST_GAP;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_CHECK;
          end
        end else begin
          w_s_nxt   = r_dir;
          w_r_nxt   = ~r_dir;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CHECK_LAST) begin
          w_done_nxt  = 1'b1;
          w_fail_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, drive and status registers; reset drops s/r without a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_done  <= w_done_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  // Sticky error; a new failure outranks a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_done_nxt && w_fail_nxt) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_s         = r_s;
  assign o_r         = r_r;
  assign o_done      = r_done;
  assign o_fail      = r_fail;
  assign o_err       = r_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: two instances (default timing and a short
// PULSE=1/GAP=0/TIMEOUT=3 variant) each driving a behavioural SR latch with a
// configurable response delay, stuck-q and invalid-qb faults.
module tb_sr_latch_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd_valid, cmd_set, q_fb, qb_fb, err_clr;
  logic [1:0] cmd_ready, s_w, r_w, done_w, fail_w, err_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // latch model state per unit
  logic q_m     [2];
  int   dly_m   [2];
  bit   stuck_m [2];
  bit   bad_m   [2];
  logic hs      [2][16];
  logic hr      [2][16];
  bit   err_exp [2];
  int   cmds    [2];
  int   done_total [2];

  sr_latch_driver u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid[0]), .i_cmd_set(cmd_set[0]),
    .o_cmd_ready(cmd_ready[0]), .i_q_fb(q_fb[0]), .i_qb_fb(qb_fb[0]),
    .o_s(s_w[0]), .o_r(r_w[0]), .o_done(done_w[0]), .o_fail(fail_w[0]),
    .o_err(err_w[0]), .i_err_clr(err_clr[0]));

  sr_latch_driver #(.PULSE_CYC(1), .GAP_CYC(0), .TIMEOUT_CYC(3), .CNT_W(8)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid[1]), .i_cmd_set(cmd_set[1]),
    .o_cmd_ready(cmd_ready[1]), .i_q_fb(q_fb[1]), .i_qb_fb(qb_fb[1]),
    .o_s(s_w[1]), .o_r(r_w[1]), .o_done(done_w[1]), .o_fail(fail_w[1]),
    .o_err(err_w[1]), .i_err_clr(err_clr[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Behavioural latch: drive seen at negedge c takes effect at negedge c+dly.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      hs[u][cyc % 16] = s_w[u];
      hr[u][cyc % 16] = r_w[u];
      if (!stuck_m[u] && cyc >= dly_m[u]) begin
        if (hs[u][(cyc - dly_m[u]) % 16]) q_m[u] = 1'b1;
        else if (hr[u][(cyc - dly_m[u]) % 16]) q_m[u] = 1'b0;
      end
      q_fb[u]  = q_m[u];
      qb_fb[u] = bad_m[u] ? q_m[u] : ~q_m[u];
    end
  end

  // Every-cycle invariants and completion counting.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int u = 0; u < 2; u++) begin
        total++;
        assert ((s_w[u] & r_w[u]) === 1'b0) else begin
          bad++;
          $error("FAIL s_and_r unit=%0d observed=1 expected=0", u);
        end
        total++;
        assert ((fail_w[u] & ~done_w[u]) === 1'b0) else begin
          bad++;
          $error("FAIL fail_without_done unit=%0d observed=1 expected=0", u);
        end
        if (done_w[u] === 1'b1) done_total[u]++;
      end
    end
  end

  task automatic run_cmd(input int u, input bit dir, input int dly, input bit stuck,
                         input bit badqb, input bit toggle, input bit hold_clr);
    int p, g, t, n, c0, tq, m, exp_dc, s_cnt, r_cnt, last_hi, dc;
    bit q_before, exp_fail, got_fail, got_err, seen;
    p = (u == 1) ? 1 : 4;
    g = (u == 1) ? 0 : 2;
    t = (u == 1) ? 3 : 16;
    repeat (6) @(negedge clk);
    dly_m[u]   = dly;
    stuck_m[u] = stuck;
    bad_m[u]   = badqb;
    q_before   = q_m[u];
    chkb("ready_idle", cmd_ready[u], 1'b1);
    cmd_valid[u] = 1'b1;
    cmd_set[u]   = dir;
    if (hold_clr) err_clr[u] = 1'b1;
    @(negedge clk);
    n = cyc;
    cmds[u]++;
    cmd_valid[u] = 1'b0;
    chkb("ready_busy", cmd_ready[u], 1'b0);
    s_cnt = 0; r_cnt = 0; last_hi = -1; seen = 0; dc = 0; got_fail = 0; got_err = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (s_w[u] === 1'b1) begin s_cnt++; last_hi = cyc; end
      if (r_w[u] === 1'b1) begin r_cnt++; last_hi = cyc; end
      if (done_w[u] === 1'b1) begin
        seen = 1;
        dc = cyc;
        got_fail = fail_w[u];
        got_err  = err_w[u];
        cmd_valid[u] = 1'b0;
        err_clr[u]   = 1'b0;
      end else begin
        if (toggle) begin
          cmd_valid[u] = 1'($urandom_range(0, 1));
          cmd_set[u]   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end
    if (!seen) begin
      cmd_valid[u] = 1'b0;
      err_clr[u]   = 1'b0;
      chk("done_timeout", 0, 1);
      bad_m[u] = 1'b0;
      return;
    end
    // expected completion from the latch response time
    c0 = n + p + g;
    exp_fail = 0;
    m = c0;
    if (badqb) exp_fail = 1;
    else if (q_before == dir) m = c0;
    else if (stuck) exp_fail = 1;
    else begin
      tq = n + dly + 2;
      if (tq <= c0 + t - 1) m = (tq > c0) ? tq : c0;
      else exp_fail = 1;
    end
    exp_dc = exp_fail ? (c0 + t) : (m + 1);
    if (exp_fail) err_exp[u] = 1;
    else if (hold_clr) err_exp[u] = 0;
    chk("s_cycles", s_cnt, dir ? p : 0);
    chk("r_cycles", r_cnt, dir ? 0 : p);
    chk("last_drive_cycle", last_hi - n, p - 1);
    chk("done_cycle", dc - n, exp_dc - n);
    chkb("fail", got_fail, exp_fail);
    chkb("err", got_err, err_exp[u]);
    @(negedge clk);
    chkb("done_one_cycle", done_w[u], 1'b0);
    chkb("ready_after_done", cmd_ready[u], 1'b1);
    bad_m[u] = 1'b0;
  endtask

  task automatic clr_err(input int u);
    @(negedge clk);
    err_clr[u] = 1'b1;
    @(negedge clk);
    err_clr[u] = 1'b0;
    err_exp[u] = 0;
    chkb("err_clr", err_w[u], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = '0; cmd_set = '0; err_clr = '0;
    for (int u = 0; u < 2; u++) begin
      q_m[u] = 1'b0; dly_m[u] = 1; stuck_m[u] = 0; bad_m[u] = 0;
      err_exp[u] = 0; cmds[u] = 0; done_total[u] = 0;
      for (int k = 0; k < 16; k++) begin hs[u][k] = 1'b0; hr[u][k] = 1'b0; end
    end
    q_fb = 2'b00; qb_fb = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("rst_ready", cmd_ready[0], 1'b1);
    chkb("rst_s", s_w[0], 1'b0);
    chkb("rst_r", r_w[0], 1'b0);
    chkb("rst_done", done_w[0], 1'b0);
    chkb("rst_fail", fail_w[0], 1'b0);
    chkb("rst_err", err_w[0], 1'b0);
    chkb("rst_ready1", cmd_ready[1], 1'b1);

    // set, reset, stuck, err stickiness
    run_cmd(0, 1'b1, 1, 0, 0, 0, 0);
    run_cmd(0, 1'b0, 1, 0, 0, 0, 0);
    run_cmd(0, 1'b1, 2, 1, 0, 0, 0);
    run_cmd(0, 1'b0, 1, 0, 0, 0, 0);
    clr_err(0);
    // invalid q==qb feedback, clear during pass, set-wins-over-clear
    run_cmd(0, 1'b1, 1, 0, 1, 0, 0);
    run_cmd(0, 1'b1, 3, 0, 0, 0, 1);
    run_cmd(0, 1'b0, 1, 1, 0, 0, 1);
    clr_err(0);

    // reset in the middle of a pulse
    repeat (6) @(negedge clk);
    dly_m[0] = 1; stuck_m[0] = 0;
    cmd_valid[0] = 1'b1; cmd_set[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chkb("mid_pulse_s_high", s_w[0], 1'b1);
    #1 rst_n = 1'b0;
    #1 chkb("async_s_drop", s_w[0], 1'b0);
    chkb("async_r_low", r_w[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    err_exp[0] = 0; err_exp[1] = 0;
    repeat (6) @(negedge clk);
    chkb("ready_after_rst", cmd_ready[0], 1'b1);
    chk("no_done_after_rst", done_total[0], cmds[0]);

    // short-timing instance
    run_cmd(1, 1'b1, 1, 0, 0, 0, 0);
    run_cmd(1, 1'b0, 5, 0, 0, 0, 0);
    run_cmd(1, 1'b0, 1, 0, 0, 0, 0);
    clr_err(1);

    // randomized commands with cmd_valid toggling while busy
    for (int i = 0; i < 200; i++)
      run_cmd(0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
              ($urandom_range(0, 9) == 0), 0, 1, 0);
    for (int i = 0; i < 40; i++)
      run_cmd(1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
              ($urandom_range(0, 9) == 0), 0, 1, 0);

    repeat (5) @(negedge clk);
    chk("done_count_u0", done_total[0], cmds[0]);
    chk("done_count_u1", done_total[1], cmds[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Clocked controller that drives the set/reset inputs of an srlatch from a valid/ready command interface. It is the initiator side of the latch's s/r interface. It generates clean, width-controlled s or r pulses with a guaranteed dead time, and never allows s=r=1. It then confirms through synchronized q/qb feedback that the latch reached the commanded state, and reports pass or fail.

Parameters:
PULSE_CYC, 4, clock cycles s or r is held high per command (>=1)
GAP_CYC, 2, dead-time cycles with s=r=0 after each pulse (>=0; 0 skips GAP)
TIMEOUT_CYC, 16, maximum CHECK cycles to wait for matching feedback (>=3)
CNT_W, 8, width of the shared cycle counter; must hold max(PULSE_CYC, GAP_CYC, TIMEOUT_CYC)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_set  in  1  1 = set latch (q->1), 0 = reset latch (q->0); sampled on handshake
cmd_ready  out  1  high only in IDLE
q_fb  in  1  latch q, asynchronous to clk
qb_fb  in  1  latch qb, asynchronous to clk
s  out  1  latch set drive, registered
r  out  1  latch reset drive, registered
done  out  1  one-cycle pulse at command completion
fail  out  1  valid with done; 1 = timeout, latch did not reach commanded state
err  out  1  sticky error flag, set on any fail
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async assert, sync release via clk edge): state=IDLE, s=0, r=0, done=0, fail=0, err=0, counter=0, sync flops=0. cmd_ready=1 after reset.
- Reset mid-operation forces s=r=0 immediately, without waiting for a clock. The pending command is dropped with no done.
- q_fb and qb_fb each pass through a 2-flop synchronizer. Internal qs/qbs lag the inputs by 2 cycles.
- Invariant: s&r==0 in every cycle. s and r are flops written only from the FSM.
- FSM states: IDLE, PULSE, GAP, CHECK.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge N: capture cmd_set into dir, load counter, go to PULSE. At the same edge set s=dir and r=~dir.
  - cmd_valid while not ready is ignored and not queued. The master holds it.
- PULSE:
  - s or r stays high for exactly PULSE_CYC cycles (edges N..N+PULSE_CYC).
  - At edge N+PULSE_CYC: s=r=0. Go to GAP, or to CHECK if GAP_CYC=0.
- GAP: s=r=0 for GAP_CYC cycles, then go to CHECK with the counter cleared.
- CHECK:
  - Each cycle, compare qs==dir && qbs==~dir. Equal q and qb (the latch's forbidden/invalid state) counts as a mismatch.
  - On match in CHECK cycle k (1<=k<=TIMEOUT_CYC): at the next edge, done=1 and fail=0 for one cycle, go to IDLE.
  - If no match in TIMEOUT_CYC cycles: done=1, fail=1, err=1, go to IDLE.
- done/fail are registered and high for exactly one cycle. fail=0 whenever done=0.
- err_clr clears err on the next edge in any state. If a fail and err_clr occur in the same cycle, the set wins (err=1).
- A command matching the current latch state is still fully pulsed and checked. It completes in CHECK cycle 1 if the feedback is already settled.
- Minimum command period: 1 (handshake) + PULSE_CYC + GAP_CYC + k cycles. Back-to-back commands are accepted the cycle after done.

Test Plan:
- Set command, defaults, bench latch model with 1-cycle delay: cmd_valid=1, cmd_set=1 at cycle 10 -> s=1 for cycles 11-14, r=0 throughout, s=r=0 cycles 15-16, done=1 fail=0 at about cycle 20; q=1, qb=0.
- Reset command after set: cmd_set=0 -> r=1 for 4 cycles, s never high, done with fail=0; q=0, qb=1; cmd_ready returns to 1 the cycle after done.
- Stuck latch (q_fb forced 0 while setting): cmd_set=1 -> after PULSE+GAP, 16 CHECK cycles then done=1, fail=1, err=1. err stays 1 across a following passing command until err_clr pulses.
- Reset mid-pulse: assert rst_n=0 during PULSE cycle 2 -> s drops to 0 within the reset assertion (no clk edge needed). After release: cmd_ready=1, no done.
- Parameter sweep PULSE_CYC=1, GAP_CYC=0, TIMEOUT_CYC=3: s high exactly 1 cycle, no GAP cycles; a latch delay of 1 passes and a latch delay of 5 fails.
- Random 200 commands with cmd_valid toggling while busy: assertion s&r==0 every cycle; done count equals accepted handshake count; no command accepted while cmd_ready=0.
